// File: rtl/snn_aer_pkg.sv
// Shared AER definitions: event layout, scanner states and the bit-vector
// helpers used to serialise spike vectors.
package snn_aer_pkg;

  localparam int AER_INDEX_WIDTH = 16;
  localparam int AER_MAX_INPUTS  = 65536;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } aer_state_t;

  // Default event layout for the standard 16-bit timestamp configuration
  typedef struct packed {
    logic [15:0]                  timestamp;
    logic [AER_INDEX_WIDTH-1:0]   index;
  } aer_event_t;

  // Index of the lowest set bit among the first n bits of v (0 when none set)
  function automatic logic [AER_INDEX_WIDTH-1:0] lowest_set_index(
    input logic [AER_MAX_INPUTS-1:0] v,
    input int                        n
  );
    lowest_set_index = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (v[i]) lowest_set_index = AER_INDEX_WIDTH'(i);
    end
  endfunction

  function automatic logic [AER_INDEX_WIDTH:0] popcount(
    input logic [AER_MAX_INPUTS-1:0] v,
    input int                        n
  );
    popcount = '0;
    for (int i = 0; i < n; i++) begin
      popcount = popcount + {{AER_INDEX_WIDTH{1'b0}}, v[i]};
    end
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; dout shows the head entry and
// reads as zero while empty.
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic [AW:0]           count
);

  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; emptiness alone decides what dout shows
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/spike_aer_encoder.sv
// Serialises per-timestep spike vectors into {timestamp, index} address
// events, lowest index first, buffered in a FWFT FIFO with drop accounting.
module spike_aer_encoder
  import snn_aer_pkg::*;
#(
  parameter int  NUM_INPUTS      = 4,
  parameter int  TIMESTAMP_WIDTH = 16,
  parameter int  FIFO_DEPTH      = 16,
  localparam int FIFO_ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clr,
  input  logic                                 en,
  input  logic [NUM_INPUTS-1:0]                spike_in,
  output logic [TIMESTAMP_WIDTH+AER_INDEX_WIDTH-1:0] event_data,
  output logic                                 event_valid,
  input  logic                                 event_ready,
  output logic [FIFO_ADDR_WIDTH:0]             fifo_count,
  output logic [31:0]                          drop_count,
  output logic                                 busy
);

  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  typedef struct packed {
    logic [TIMESTAMP_WIDTH-1:0] timestamp;
    logic [AER_INDEX_WIDTH-1:0] index;
  } evt_t;

  aer_state_t                 state;
  logic [NUM_INPUTS-1:0]      snapshot;
  logic [NUM_INPUTS-1:0]      remaining;
  logic [TIMESTAMP_WIDTH-1:0] timestamp;
  logic [TIMESTAMP_WIDTH-1:0] snap_ts;
  logic [IDX_W-1:0]           scan_idx;
  logic [AER_INDEX_WIDTH:0]   spike_pop;
  evt_t                       push_evt;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       push;
  logic                       last_bit;
  logic                       sample;
  logic                       accept;
  logic                       drop;

  function automatic logic [31:0] sat_add(
    input logic [31:0]              a,
    input logic [AER_INDEX_WIDTH:0] b
  );
    logic [32:0] s;
    s       = {1'b0, a} + 33'(b);
    sat_add = s[32] ? '1 : s[31:0];
  endfunction

  assign scan_idx  = IDX_W'(lowest_set_index(AER_MAX_INPUTS'(snapshot), NUM_INPUTS));
  assign remaining = snapshot & (snapshot - NUM_INPUTS'(1));
  assign spike_pop = popcount(AER_MAX_INPUTS'(spike_in), NUM_INPUTS);

  assign push     = (state == SCAN) && !fifo_full;
  assign last_bit = push && (remaining == '0);
  assign sample   = en && (|spike_in);
  // A new vector may enter on the cycle the previous one finishes draining
  assign accept   = sample && ((state == IDLE) || last_bit);
  assign drop     = sample && !accept;

  assign push_evt.timestamp = snap_ts;
  assign push_evt.index     = AER_INDEX_WIDTH'(scan_idx);

  assign event_valid = !fifo_empty;
  assign busy        = (state == SCAN) || !fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      snapshot   <= '0;
      snap_ts    <= '0;
      timestamp  <= '0;
      drop_count <= '0;
    end else if (clr) begin
      state      <= IDLE;
      snapshot   <= '0;
      snap_ts    <= '0;
      timestamp  <= '0;
      drop_count <= '0;
    end else begin
      if (en) timestamp <= timestamp + TIMESTAMP_WIDTH'(1);

      if (accept) begin
        snapshot <= spike_in;
        snap_ts  <= timestamp;
        state    <= SCAN;
      end else begin
        if (push)     snapshot <= remaining;
        if (last_bit) state    <= IDLE;
      end

      if (drop) drop_count <= sat_add(drop_count, spike_pop);
    end
  end

  sync_fifo #(
    .DATA_WIDTH (TIMESTAMP_WIDTH + AER_INDEX_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .pop   (event_ready),
    .din   (push_evt),
    .dout  (event_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Bench for spike_aer_encoder: per-cycle vector table, directed corner
// sequences and a randomized run against a queue-based event model.
module tb_spike_aer_encoder;

  localparam int NI    = 4;
  localparam int TSW   = 4;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int EW    = TSW + 16;
  localparam int NROWS = 36;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          en;
  logic [NI-1:0] spike_in;
  logic [EW-1:0] event_data;
  logic          event_valid;
  logic          event_ready;
  logic [AW:0]   fifo_count;
  logic [31:0]   drop_count;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spike_aer_encoder #(
    .NUM_INPUTS      (NI),
    .TIMESTAMP_WIDTH (TSW),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .en          (en),
    .spike_in    (spike_in),
    .event_data  (event_data),
    .event_valid (event_valid),
    .event_ready (event_ready),
    .fifo_count  (fifo_count),
    .drop_count  (drop_count),
    .busy        (busy)
  );

  typedef struct {
    logic          en;
    logic [NI-1:0] spike;
    logic          ready;
    logic          vld;
    logic [EW-1:0] data;
    logic [AW:0]   cnt;
    logic          bsy;
  } row_t;

  row_t tbl [NROWS];

  // Reference model state
  int            m_ts;
  int            m_pts;
  int            pend[$];
  logic [EW-1:0] mq[$];
  longint        m_drop;

  function automatic logic [EW-1:0] ev(input int ts, input int idx);
    ev = {TSW'(ts), 16'(idx)};
  endfunction

  function automatic row_t mk(input logic e, input logic [NI-1:0] s, input logic r,
                              input logic v, input logic [EW-1:0] d,
                              input logic [AW:0] c, input logic b);
    mk.en = e; mk.spike = s; mk.ready = r;
    mk.vld = v; mk.data = d; mk.cnt = c; mk.bsy = b;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input int idx, input logic v,
                         input logic [EW-1:0] d, input logic [AW:0] c,
                         input logic [31:0] dr, input logic b);
    chk({name, "_valid"}, idx, event_valid, v);
    chk({name, "_data"},  idx, event_data,  d);
    chk({name, "_count"}, idx, fifo_count,  c);
    chk({name, "_drop"},  idx, drop_count,  dr);
    chk({name, "_busy"},  idx, busy,        b);
  endtask

  task automatic cyc(input logic e, input logic [NI-1:0] s, input logic r);
    en = e; spike_in = s; event_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1; en = 1'b0; spike_in = '0;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic model_reset();
    m_ts = 0; m_pts = 0; m_drop = 0;
    pend.delete();
    mq.delete();
  endtask

  // One clock of the event-level model: queue of pending indices feeding a bounded queue
  task automatic model_step(input logic c, input logic e, input logic [NI-1:0] s,
                            input logic r);
    bit do_pop, do_push, last, smp, acc;
    if (c) begin
      model_reset();
      return;
    end
    do_pop  = (mq.size() > 0) && r;
    do_push = (pend.size() > 0) && (mq.size() < DEPTH);
    last    = do_push && (pend.size() == 1);
    smp     = e && (s != '0);
    acc     = smp && ((pend.size() == 0) || last);
    if (do_pop)  void'(mq.pop_front());
    if (do_push) mq.push_back(ev(m_pts, pend.pop_front()));
    if (acc) begin
      for (int i = 0; i < NI; i++) if (s[i]) pend.push_back(i);
      m_pts = m_ts;
    end else if (smp) begin
      m_drop = m_drop + $countones(s);
      if (m_drop > 64'hFFFF_FFFF) m_drop = 64'hFFFF_FFFF;
    end
    if (e) m_ts = (m_ts + 1) % (1 << TSW);
  endtask

  initial begin
    logic [EW-1:0] exp_heads [5];
    int            rp;
    logic          e, r, c;
    logic [NI-1:0] s;

    rst = 1'b1; clr = 1'b0; en = 1'b0; spike_in = '0; event_ready = 1'b0;

    for (int k = 0; k < NROWS; k++) tbl[k] = mk(1'b1, 4'b0000, 1'b1, 1'b0, '0, '0, 1'b0);
    tbl[5]  = mk(1'b1, 4'b0100, 1'b1, 1'b0, '0,        0, 1'b0);
    tbl[6]  = mk(1'b1, 4'b0000, 1'b1, 1'b0, '0,        0, 1'b1);
    tbl[7]  = mk(1'b1, 4'b0000, 1'b1, 1'b1, ev(5, 2),  1, 1'b1);
    tbl[19] = mk(1'b1, 4'b1011, 1'b1, 1'b0, '0,        0, 1'b0);
    tbl[20] = mk(1'b1, 4'b0000, 1'b1, 1'b0, '0,        0, 1'b1);
    tbl[21] = mk(1'b1, 4'b0000, 1'b1, 1'b1, ev(3, 0),  1, 1'b1);
    tbl[22] = mk(1'b1, 4'b0000, 1'b1, 1'b1, ev(3, 1),  1, 1'b1);
    tbl[23] = mk(1'b1, 4'b0000, 1'b1, 1'b1, ev(3, 3),  1, 1'b1);
    tbl[31] = mk(1'b1, 4'b0001, 1'b1, 1'b0, '0,        0, 1'b0);
    tbl[32] = mk(1'b1, 4'b0010, 1'b1, 1'b0, '0,        0, 1'b1);
    tbl[33] = mk(1'b1, 4'b0000, 1'b1, 1'b1, ev(15, 0), 1, 1'b1);
    tbl[34] = mk(1'b1, 4'b0000, 1'b1, 1'b1, ev(0, 1),  1, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Row k: expected outputs observed during cycle k, then cycle k's inputs
    for (int k = 0; k < NROWS; k++) begin
      chk_all("tbl", k, tbl[k].vld, tbl[k].data, tbl[k].cnt, 32'd0, tbl[k].bsy);
      cyc(tbl[k].en, tbl[k].spike, tbl[k].ready);
    end

    // Back-to-back: second vector accepted on the last-bit cycle of the first
    do_clr();
    repeat (10) cyc(1'b1, 4'b0000, 1'b1);
    cyc(1'b1, 4'b0011, 1'b1);
    cyc(1'b0, 4'b0000, 1'b1);
    chk("b2b_head0", 0, event_data, ev(10, 0));
    cyc(1'b1, 4'b1000, 1'b1);
    chk("b2b_head1", 1, event_data, ev(10, 1));
    chk("b2b_busy", 1, busy, 1'b1);
    cyc(1'b0, 4'b0000, 1'b1);
    chk("b2b_head2", 2, event_data, ev(11, 3));
    cyc(1'b0, 4'b0000, 1'b1);
    chk_all("b2b_end", 0, 1'b0, '0, '0, 32'd0, 1'b0);

    // Overflow with consumer stalled
    do_clr();
    repeat (3) cyc(1'b1, 4'b1111, 1'b0);
    repeat (2) cyc(1'b0, 4'b0000, 1'b0);
    chk_all("ovf_full", 0, 1'b1, ev(0, 0), 3'd4, 32'd8, 1'b1);
    cyc(1'b1, 4'b0001, 1'b0);
    chk("ovf_stall_cnt", 0, fifo_count, 3'd4);
    chk("ovf_stall_busy", 0, busy, 1'b1);
    cyc(1'b1, 4'b0110, 1'b0);
    chk("ovf_stall_cnt", 1, fifo_count, 3'd4);
    chk("ovf_drop", 0, drop_count, 32'd10);
    exp_heads = '{ev(0, 0), ev(0, 1), ev(0, 2), ev(0, 3), ev(3, 0)};
    for (int i = 0; i < 5; i++) begin
      chk("ovf_drain", i, event_data, exp_heads[i]);
      cyc(1'b0, 4'b0000, 1'b1);
    end
    chk_all("ovf_end", 0, 1'b0, '0, '0, 32'd10, 1'b0);

    // Simultaneous push and pop at DEPTH-1
    do_clr();
    cyc(1'b1, 4'b0111, 1'b0);
    repeat (3) cyc(1'b0, 4'b0000, 1'b0);
    cyc(1'b1, 4'b0001, 1'b0);
    chk("pp_cnt_before", 0, fifo_count, 3'd3);
    chk("pp_head_before", 0, event_data, ev(0, 0));
    cyc(1'b0, 4'b0000, 1'b1);
    chk("pp_cnt_after", 0, fifo_count, 3'd3);
    exp_heads = '{ev(0, 1), ev(0, 2), ev(1, 0), '0, '0};
    for (int i = 0; i < 3; i++) begin
      chk("pp_drain", i, event_data, exp_heads[i]);
      cyc(1'b0, 4'b0000, 1'b1);
    end
    chk("pp_empty", 0, event_valid, 1'b0);

    // Soft clear in the middle of a scan
    do_clr();
    cyc(1'b1, 4'b1111, 1'b0);
    cyc(1'b0, 4'b0000, 1'b0);
    cyc(1'b1, 4'b1111, 1'b0);
    chk("clr_pre_cnt", 0, fifo_count, 3'd2);
    chk("clr_pre_drop", 0, drop_count, 32'd4);
    clr = 1'b1;
    cyc(1'b1, 4'b1111, 1'b1);
    clr = 1'b0;
    chk_all("clr_mid", 0, 1'b0, '0, '0, 32'd0, 1'b0);
    cyc(1'b1, 4'b0010, 1'b1);
    cyc(1'b0, 4'b0000, 1'b1);
    chk("clr_after_vld", 0, event_valid, 1'b1);
    chk("clr_after_data", 0, event_data, ev(0, 1));

    // Asynchronous reset between clock edges
    cyc(1'b1, 4'b0011, 1'b0);
    cyc(1'b1, 4'b0100, 1'b0);
    chk("rst_pre_cnt", 0, fifo_count, 3'd2);
    #3;
    rst = 1'b1;
    #1;
    chk_all("rst_async", 0, 1'b0, '0, '0, 32'd0, 1'b0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Randomized run against the event model
    do_clr();
    model_reset();
    rp = 90;
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) rp = (n / 250) % 3 == 0 ? 90 : ((n / 250) % 3 == 1 ? 50 : 10);
      e = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 2) == 0) ? NI'($urandom) : '0;
      r = ($urandom_range(0, 99) < rp);
      c = ($urandom_range(0, 299) == 0);
      clr = c; en = e; spike_in = s; event_ready = r;
      @(posedge clk);
      model_step(c, e, s, r);
      #1;
      clr = 1'b0;
      chk_all("rnd", n, mq.size() > 0, (mq.size() > 0) ? mq[0] : '0,
              (AW + 1)'(mq.size()), m_drop[31:0], (pend.size() > 0) || (mq.size() > 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spike_aer_encoder.md
Name: spike_aer_encoder

Overview:
Downstream of the IF network: converts the per-timestep output spike vector into address-event (AER) words {timestamp, neuron index}. Events are buffered in a FIFO and drained over a valid/ready interface, which the AXI register block or a DMA reads.
Multiple spikes in one timestep are serialised lowest index first, one event per cycle. Spikes that cannot be accepted are counted, never silently lost.

Parameters:
NUM_INPUTS, 4, width of the spike vector (number of output neurons); 1..65536
TIMESTAMP_WIDTH, 16, timestamp field width; event word is {timestamp, 16-bit index}
FIFO_DEPTH, 16, event FIFO entries; power of two, >=2
FIFO_ADDR_WIDTH, $clog2(FIFO_DEPTH), derived; do not override

Ports:
clk  in  1  single clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
clr  in  1  synchronous soft clear (driven by network reset); highest priority after rst
en  in  1  network running; timestamp advances and spike_in is sampled only when high
spike_in  in  NUM_INPUTS  output spike vector for the current timestep
event_data  out  TIMESTAMP_WIDTH+16  {timestamp, zero-extended neuron index}
event_valid  out  1  FIFO non-empty
event_ready  in  1  consumer accepts the head word when valid && ready
fifo_count  out  FIFO_ADDR_WIDTH+1  current FIFO occupancy
drop_count  out  32  spikes dropped since the last rst/clr; saturates at 2^32-1
busy  out  1  scanner in SCAN state or FIFO non-empty

Behaviour:
- Reset (rst async, or clr sync): timestamp=0, state=IDLE, snapshot=0, FIFO empty, fifo_count=0, event_valid=0, event_data=0, drop_count=0, busy=0.
- Timestamp counter: increments by 1 every cycle with en=1; wraps modulo 2^TIMESTAMP_WIDTH. A sampled vector is tagged with the pre-increment value.
- Sample condition: en && |spike_in.
- Sample is accepted when state==IDLE, or when state==SCAN and the final remaining bit is pushed in this same cycle (back-to-back).
- Accepted sample: snapshot<=spike_in, snap_ts<=timestamp, state<=SCAN.
- Otherwise the sample is dropped and drop_count += popcount(spike_in), saturating.
- State machine:
  - IDLE -> SCAN on an accepted sample.
  - SCAN: idx = lowest set bit of snapshot.
  - SCAN with FIFO not full: push {snap_ts, idx}, clear that bit.
  - SCAN with FIFO full: hold; no push, snapshot unchanged.
  - SCAN -> IDLE when the last bit is pushed, unless a new sample is accepted in that cycle (stays in SCAN).
- Latency: spike at cycle t with idle scanner and empty FIFO gives the first event_valid at t+2. Later events from the same vector follow at 1 per cycle.
- FIFO: first-word-fall-through; event_data = head entry, 0 when empty.
  - Push only when not full.
  - Pop on event_valid && event_ready.
  - Simultaneous push and pop: both take effect, count unchanged.
  - Pop on empty is ignored.
  - Push on full never occurs, because the scanner stalls.
- en low: timestamp frozen, no sampling. Scanning and draining continue.
- clr mid-scan: pending snapshot and FIFO contents are discarded; next cycle behaves as after reset.
- Index width: idx is $clog2(NUM_INPUTS) bits (min 1), zero-extended to 16.

Decomposition:
- Package snn_aer_pkg holds:
  - constant AER_INDEX_WIDTH=16;
  - typedef enum {IDLE, SCAN} aer_state_t;
  - packed struct aer_event_t {timestamp, index}.
- One sub-module: sync_fifo.
  - Parameters: DATA_WIDTH, DEPTH.
  - Ports: clk/rst/clr, push/pop, din/dout, full/empty, count.
  - FWFT, so it is reusable elsewhere in the network.
- Priority encoder and popcount stay inline as functions in the package.

Test Plan:
- Single spike: NUM_INPUTS=4, en=1 from cycle 0, spike_in=4'b0100 at cycle 5, event_ready=1 -> one event {ts=5, idx=2} with event_valid first high at cycle 7; drop_count=0.
- Multi-spike serialisation: spike_in=4'b1011 at ts=3 -> events idx 0,1,3 on consecutive cycles, all ts=3.
- Back-to-back timesteps: 4'b0011 at ts=10, 4'b1000 at ts=11 -> two events accepted (second on the last-bit cycle), third event {11,3}; no drops.
- Backpressure/overflow: FIFO_DEPTH=4, event_ready=0, spike_in=4'b1111 for 3 consecutive cycles:
  - fifo_count=4 and scanner stalled;
  - drop_count counts the spikes of samples arriving while stalled (=8 for the 2 later vectors);
  - after event_ready=1, drain order is idx 0,1,2,3 at the first ts.
- Simultaneous push/pop at full-1: count stays constant; data ordering is preserved.
- Timestamp wrap and clr: TIMESTAMP_WIDTH=4, spike at ts=15 then ts=0 -> ts fields 15 then 0.
- clr asserted mid-scan -> event_valid=0, fifo_count=0, drop_count=0 next cycle; rst asserted asynchronously mid-cycle clears all outputs immediately.
